// File: rtl/xtea_stream_adapter.sv
// Stream bridge for a 128-bit XTEA core: packs four 32-bit words into a block, launches the core and streams the result out.
// Optional core-wait watchdog is enabled by defining XTEA_ADAPTER_TIMEOUT_EN.
module xtea_stream_adapter #(
  parameter int WORD_SIZE = 128,
  parameter int BUS_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 key_we,
  input  logic [1:0]           key_addr,
  input  logic [BUS_WIDTH-1:0] key_data,
  output logic                 key_locked,
  output logic [WORD_SIZE-1:0] core_data_in,
  output logic [WORD_SIZE-1:0] core_key,
  output logic                 core_start,
  input  logic                 core_ready,
  input  logic [WORD_SIZE-1:0] core_data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 timeout_err
);

  localparam int NW = WORD_SIZE / BUS_WIDTH;

  typedef enum logic [1:0] {IDLE, START, WAIT, DRAIN} state_t;

  state_t                       state_reg;
  logic [1:0]                   beat_reg;
  logic [1:0]                   out_idx_reg;
  logic [1:0]                   out_idx_next;
  logic [NW-1:0][BUS_WIDTH-1:0] block_reg;
  logic [NW-1:0][BUS_WIDTH-1:0] key_reg;
  logic [NW-1:0][BUS_WIDTH-1:0] result_reg;

  // Word 0 on the bus is the most significant slot, hence the inverted index.
  assign in_ready     = (state_reg == IDLE);
  assign key_locked   = (state_reg != IDLE);
  assign core_data_in = block_reg;
  assign core_key     = key_reg;
  assign out_idx_next = out_idx_reg + 2'd1;

`ifdef XTEA_ADAPTER_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_reg;
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_reg <= '0;
    end else if (key_we && state_reg == IDLE) begin
      key_reg[~key_addr] <= key_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      beat_reg    <= 2'd0;
      out_idx_reg <= 2'd0;
      block_reg   <= '0;
      result_reg  <= '0;
      core_start  <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
`ifdef XTEA_ADAPTER_TIMEOUT_EN
      wd_reg      <= 8'd0;
      timeout_err <= 1'b0;
`endif
    end else begin
      core_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            block_reg[~beat_reg] <= in_data;
            beat_reg             <= beat_reg + 2'd1;
            if (beat_reg == 2'd3) begin
              state_reg  <= START;
              core_start <= 1'b1;
            end
          end
        end
        START: begin
          state_reg <= WAIT;
`ifdef XTEA_ADAPTER_TIMEOUT_EN
          wd_reg    <= 8'd0;
`endif
        end
        WAIT: begin
          if (core_ready) begin
            result_reg  <= core_data_out;
            out_data    <= core_data_out[WORD_SIZE-1 -: BUS_WIDTH];
            out_valid   <= 1'b1;
            out_last    <= 1'b0;
            out_idx_reg <= 2'd0;
            state_reg   <= DRAIN;
          end
`ifdef XTEA_ADAPTER_TIMEOUT_EN
          else if (wd_reg == WD_LAST) begin
            // Core never answered: abandon the block and flag it until reset.
            timeout_err <= 1'b1;
            block_reg   <= '0;
            state_reg   <= IDLE;
          end else begin
            wd_reg <= wd_reg + 8'd1;
          end
`endif
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_idx_reg == 2'd3) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state_reg <= IDLE;
            end else begin
              out_idx_reg <= out_idx_next;
              out_data    <= result_reg[~out_idx_next];
              out_last    <= (out_idx_next == 2'd3);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xtea_stream_adapter.sv
// Scoreboard bench for xtea_stream_adapter with a behavioural core stub (ready 100 cycles after start, result = data ^ key).
module tb_xtea_stream_adapter;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         key_we = 1'b0;
  logic [1:0]   key_addr = '0;
  logic [31:0]  key_data = '0;
  logic         key_locked;
  logic [127:0] core_data_in;
  logic [127:0] core_key;
  logic         core_start;
  logic         core_ready = 1'b0;
  logic [127:0] core_data_out = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic         out_last;
  logic         timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  int          stub_cnt = 0;
  logic        stub_en  = 1'b1;

  localparam logic [127:0] KEY0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK0 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  // BLK0 ^ KEY0, worked word by word.
  localparam logic [127:0] RES0 = 128'h01326754_CDFEAB98_76451023_BA89DCEF;
  localparam logic [127:0] BLK1 = 128'hFFFFFFFF_00000000_A5A5A5A5_12345678;
  // BLK1 ^ (KEY0 with word 3 rewritten to zero during the first beat).
  localparam logic [127:0] RES1 = 128'hFFEEDDCC_44556677_2D3C0F1E_12345678;

  xtea_stream_adapter dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_we(key_we), .key_addr(key_addr), .key_data(key_data), .key_locked(key_locked),
    .core_data_in(core_data_in), .core_key(core_key), .core_start(core_start),
    .core_ready(core_ready), .core_data_out(core_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Core stub keeps running through adapter reset, so a late ready can arrive in IDLE.
  always @(posedge clock) begin
    core_ready <= 1'b0;
    if (core_start && stub_en) begin
      stub_cnt <= 100;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        core_ready    <= 1'b1;
        core_data_out <= core_data_in ^ core_key;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [127:0] r);
    for (int i = 0; i < 4; i++) exp_q.push_back(r[127-32*i -: 32]);
  endtask

  // Monitor: pops one expected word per accepted beat, and checks hold behaviour across stalls.
  initial begin
    logic        stall_prev = 1'b0;
    logic [31:0] hold_data  = '0;
    logic        hold_last  = 1'b0;
    logic [31:0] e;
    int          beat_no = 0;
    forever begin
      @(negedge clock);
      if (stall_prev) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", {out_last, out_data}, {hold_last, hold_data});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h, required no output", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e);
          check("out_last", out_last, (beat_no % 4) == 3);
          $display("beat %0d: out_data=%h out_last=%0b", beat_no, out_data, out_last);
          beat_no++;
        end
      end
      stall_prev = out_valid && !out_ready;
      hold_data  = out_data;
      hold_last  = out_last;
    end
  end

  task automatic write_key(input logic [1:0] a, input logic [31:0] d);
    @(negedge clock);
    key_we = 1'b1; key_addr = a; key_data = d;
    @(posedge clock); #1;
    key_we = 1'b0;
    $display("key write addr=%0d data=%h", a, d);
  endtask

  task automatic send_block(input logic [127:0] blk, input bit kw, input logic [1:0] ka, input logic [31:0] kd);
    @(negedge clock);
    check("in_ready_idle", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = blk[127-32*i -: 32];
      if (i == 0 && kw) begin
        key_we = 1'b1; key_addr = ka; key_data = kd;
      end
      @(posedge clock); #1;
      key_we = 1'b0;
    end
    in_valid = 1'b0;
    @(negedge clock);
    check("core_start_pulse", core_start, 1);
    check("core_data_in", core_data_in, blk);
    @(negedge clock);
    check("core_start_single", core_start, 0);
    check("key_locked_wait", key_locked, 1);
    check("in_ready_wait", in_ready, 0);
    $display("block sent %h", blk);
  endtask

  task automatic wait_drain(input bit toggle);
    logic [3:0] pat = 4'b1001;
    bit done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clock); #1;
      out_ready = toggle ? pat[c % 4] : 1'b1;
      if (exp_q.size() == 0 && !out_valid) done = 1;
    end
    out_ready = 1'b1;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", exp_q.size());
    end else begin
      check("in_ready_after_drain", in_ready, 1);
    end
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_key_locked", key_locked, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_data_in", core_data_in, 0);
    check("rst_core_key", core_key, 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_reset_values();
    reset = 1'b1;

    for (int i = 0; i < 4; i++) write_key(2'(i), KEY0[127-32*i -: 32]);
    @(negedge clock);
    check("core_key_loaded", core_key, KEY0);

    // Block 1: free-flowing output.
    push_exp(RES0);
    send_block(BLK0, 0, 2'd0, 32'h0);
    wait_drain(0);

    // Block 2: key write attempted in WAIT, output stalled with pattern 1,0,0,1.
    push_exp(RES0);
    send_block(BLK0, 0, 2'd0, 32'h0);
    repeat (3) @(negedge clock);
    key_we = 1'b1; key_addr = 2'd0; key_data = 32'hDEADBEEF;
    @(negedge clock);
    key_we = 1'b0;
    check("key_locked_on_write", key_locked, 1);
    check("core_key_unchanged", core_key, KEY0);
    wait_drain(1);

    // Block 3: key write and first input beat in the same IDLE cycle.
    push_exp(RES1);
    send_block(BLK1, 1, 2'd3, 32'h0000_0000);
    check("core_key_concurrent", core_key, {KEY0[127:32], 32'h0});
    wait_drain(0);

    // Reset while waiting on the core; the stub's late ready must be ignored.
    send_block(BLK0, 0, 2'd0, 32'h0);
    repeat (10) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_values();
    reset = 1'b1;
    repeat (120) @(negedge clock);
    check("late_ready_no_valid", out_valid, 0);
    check("late_ready_in_ready", in_ready, 1);

    // Core never answers.
    stub_en = 1'b0;
    send_block(BLK1, 0, 2'd0, 32'h0);
    repeat (250) @(negedge clock);
    check("wd_early_err", timeout_err, 0);
    check("wd_early_in_ready", in_ready, 0);
    repeat (10) @(negedge clock);
`ifdef XTEA_ADAPTER_TIMEOUT_EN
    check("wd_timeout_err", timeout_err, 1);
    check("wd_back_idle", in_ready, 1);
`else
    check("wd_no_timeout_err", timeout_err, 0);
    check("wd_still_wait", in_ready, 0);
`endif
    check("wd_no_out_valid", out_valid, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
